alu_uart_ctrl: RTL and testbench
================================

# alu_uart_ctrl

Byte-stream sequencer for the ALU datapath. It collects operand 1, operand 2 and opcode from a receive byte stream (UART RX side) and drives them onto the ALU inputs. It captures the ALU result one cycle later and streams it back as two bytes over a valid/ready transmit handshake (UART TX side). It replaces the switch/button operand-loading interface, so the ALU can be driven from a serial link.

## Interface
- NB_OP, 6, opcode width driven to ALU
- NB_DATA, 8, operand and byte width
- NB_OUT, 16, ALU result width; must equal 2*NB_DATA
- TIMEOUT_CYCLES, 100000, inter-byte timeout in clk cycles (used only with ALU_CTRL_TIMEOUT_EN)
- clk  input  1  single system clock, rising edge
- i_reset  input  1  asynchronous, active-low reset
- i_rx_data  input  NB_DATA  received byte
- i_rx_valid  input  1  one-cycle strobe, i_rx_data valid
- o_operand1  output  NB_DATA  signed operand 1 to ALU
- o_operand2  output  NB_DATA  signed operand 2 to ALU
- o_opcode  output  NB_OP  opcode to ALU
- i_alu_result  input  NB_OUT  signed combinational ALU result
- o_tx_data  output  NB_DATA  byte to transmit
- o_tx_valid  output  1  o_tx_data valid; held until accepted
- i_tx_ready  input  1  transmitter accepts when valid&ready at rising edge
- o_busy  output  1  high whenever state != IDLE
- o_error  output  1  one-cycle pulse on inter-byte timeout

## Operation
- States: IDLE, GET_OP2, GET_OPC, EXEC, SEND_HI, SEND_LO.
- IDLE: on i_rx_valid, load o_operand1 <= i_rx_data, go to GET_OP2.
- GET_OP2: on i_rx_valid, load o_operand2, go to GET_OPC.
- GET_OPC: on i_rx_valid, load o_opcode <= i_rx_data[NB_OP-1:0] (upper bits ignored), go to EXEC.
- EXEC: one cycle with no condition. Capture result_reg <= i_alu_result, go to SEND_HI.
- SEND_HI: o_tx_valid=1, o_tx_data=result_reg[NB_OUT-1:NB_DATA]. On valid&ready go to SEND_LO.
- SEND_LO: o_tx_valid=1, o_tx_data=result_reg[NB_DATA-1:0]. On valid&ready go to IDLE.
- i_rx_valid in EXEC/SEND_HI/SEND_LO: byte dropped, no state effect.
- Operand and opcode registers hold their last values after return to IDLE. They are overwritten only by new accepted bytes.
- o_tx_data is stable while o_tx_valid is high and i_tx_ready is low.

## Timing
- Reset (async assert, sync release): state IDLE; operands, opcode, result_reg, o_tx_data = 0; o_tx_valid, o_busy, o_error = 0; timeout counter = 0.
- Byte accepted at edge E0: register updates at E0 and state changes at E0.
- Opcode accepted at E0: EXEC during [E0,E1]; result captured at E1; o_tx_valid high from E1.
- With i_tx_ready held high: high byte transfers at E2, low byte at E3, IDLE from E3. Opcode-to-idle latency is 3 cycles.
- Back-to-back bytes (i_rx_valid every cycle) are accepted in IDLE/GET_OP2/GET_OPC without loss.
- Reset asserted mid-transaction: immediate return to IDLE with all reset values, and any pending tx byte is dropped.

## Configuration
- ALU_CTRL_TIMEOUT_EN defined: a counter runs in GET_OP2/GET_OPC and clears on each accepted byte and on state entry.
  - After TIMEOUT_CYCLES consecutive cycles without i_rx_valid, the block pulses o_error for one cycle and returns to IDLE. Already-loaded operands are kept.
  - If i_rx_valid coincides with expiry, the byte is accepted and no error is raised.
- ALU_CTRL_TIMEOUT_EN undefined: no counter; GET_OP2/GET_OPC wait indefinitely; o_error tied 0.

## Structure
- Shared package alu_ctrl_pkg: state encoding constants (6 states, 3-bit), RESULT_BYTES=2 constant, and the ADD/SUB opcode constants used by the bench.
- One sub-module, alu_ctrl_timeout, holds the load-clear timeout counter with an expiry flag. It is instantiated only under ALU_CTRL_TIMEOUT_EN.

## Test plan
- Bytes 0x05, 0x03, 0x20 (ADD) with ready=1 -> ALU sees 5, 3, 0x20; tx bytes 0x00 then 0x08; o_busy high 5 cycles from first byte in back-to-back case.
- Bytes 0xFB, 0x03, 0x20 -> result -2; tx 0xFF then 0xFE (sign extension kept).
- Same as first scenario with i_tx_ready low 5 cycles in SEND_HI -> o_tx_valid=1 and o_tx_data=0x00 stable for 5 cycles, then normal completion.
- Send 0x11 while in SEND_HI -> byte dropped; o_operand1 unchanged; next transaction starts cleanly in IDLE.
- With ALU_CTRL_TIMEOUT_EN, TIMEOUT_CYCLES=16: send 0x07 only -> o_error pulses once 16 cycles later; o_busy falls; o_operand1 stays 0x07; next byte is taken as operand 1.
- Assert i_reset during SEND_LO -> o_tx_valid drops immediately; all outputs reach reset values; o_busy=0.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU byte-stream sequencer: state encoding,
// result byte count and the opcode values the bench drives.
package alu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GET_OP2 = 3'd1,
    ST_GET_OPC = 3'd2,
    ST_EXEC    = 3'd3,
    ST_SEND_HI = 3'd4,
    ST_SEND_LO = 3'd5
  } state_e;

  localparam int unsigned RESULT_BYTES = 2;

  localparam logic [5:0] OPC_ADD = 6'h20;
  localparam logic [5:0] OPC_SUB = 6'h22;

endpackage

// File: rtl/alu_ctrl_timeout.sv
// Inter-byte timeout counter: counts while i_run is high, clears on i_clear or
// when idle, and flags expiry on the last cycle of the allowed window.
module alu_ctrl_timeout #(
  parameter int unsigned CYCLES = 100000
) (
  input  logic clk,
  input  logic i_reset,
  input  logic i_run,
  input  logic i_clear,
  output logic o_expired
);

  localparam int unsigned CNT_W = (CYCLES < 2) ? 1 : $clog2(CYCLES + 1);

  logic [CNT_W-1:0] cnt;

  // A byte arriving on the expiry cycle wins, so i_clear masks the flag.
  assign o_expired = i_run && !i_clear && (cnt == CNT_W'(CYCLES - 1));

  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      cnt <= '0;
    end else if (!i_run || i_clear) begin
      cnt <= '0;
    end else if (!o_expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/alu_uart_ctrl.sv
// Collects operand1/operand2/opcode bytes from the RX stream, drives the ALU and
// returns the 16-bit result as high then low byte. Optional: ALU_CTRL_TIMEOUT_EN.
module alu_uart_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned NB_OP          = 6,
  parameter int unsigned NB_DATA        = 8,
  parameter int unsigned NB_OUT         = 16,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                      clk,
  input  logic                      i_reset,
  input  logic        [NB_DATA-1:0] i_rx_data,
  input  logic                      i_rx_valid,
  output logic signed [NB_DATA-1:0] o_operand1,
  output logic signed [NB_DATA-1:0] o_operand2,
  output logic        [NB_OP-1:0]   o_opcode,
  input  logic signed [NB_OUT-1:0]  i_alu_result,
  output logic        [NB_DATA-1:0] o_tx_data,
  output logic                      o_tx_valid,
  input  logic                      i_tx_ready,
  output logic                      o_busy,
  output logic                      o_error
);

  if (NB_OUT != RESULT_BYTES * NB_DATA || NB_OP > NB_DATA || TIMEOUT_CYCLES == 0) begin : g_bad_cfg
    $error("alu_uart_ctrl: inconsistent width/timeout parameters");
  end

  state_e                    state;
  logic signed [NB_OUT-1:0]  result_reg;
  logic                      expired;

  // The transmit byte is a pure register select, so it cannot move while
  // the FSM sits in a send state waiting for ready.
  assign o_tx_data = (state == ST_SEND_LO) ? result_reg[NB_DATA-1:0]
                                           : result_reg[NB_OUT-1:NB_DATA];

`ifdef ALU_CTRL_TIMEOUT_EN
  logic to_run;
  logic error_q;

  assign to_run  = (state == ST_GET_OP2) || (state == ST_GET_OPC);
  assign o_error = error_q;

  alu_ctrl_timeout #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (clk),
    .i_reset   (i_reset),
    .i_run     (to_run),
    .i_clear   (i_rx_valid),
    .o_expired (expired)
  );
`else
  assign expired = 1'b0;
  assign o_error = 1'b0;
`endif

  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      state      <= ST_IDLE;
      o_operand1 <= '0;
      o_operand2 <= '0;
      o_opcode   <= '0;
      result_reg <= '0;
      o_tx_valid <= 1'b0;
      o_busy     <= 1'b0;
`ifdef ALU_CTRL_TIMEOUT_EN
      error_q    <= 1'b0;
`endif
    end else begin
`ifdef ALU_CTRL_TIMEOUT_EN
      error_q <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (i_rx_valid) begin
            o_operand1 <= $signed(i_rx_data);
            o_busy     <= 1'b1;
            state      <= ST_GET_OP2;
          end
        end
        ST_GET_OP2: begin
          if (i_rx_valid) begin
            o_operand2 <= $signed(i_rx_data);
            state      <= ST_GET_OPC;
          end else if (expired) begin
            o_busy <= 1'b0;
            state  <= ST_IDLE;
`ifdef ALU_CTRL_TIMEOUT_EN
            error_q <= 1'b1;
`endif
          end
        end
        ST_GET_OPC: begin
          if (i_rx_valid) begin
            o_opcode <= i_rx_data[NB_OP-1:0];
            state    <= ST_EXEC;
          end else if (expired) begin
            o_busy <= 1'b0;
            state  <= ST_IDLE;
`ifdef ALU_CTRL_TIMEOUT_EN
            error_q <= 1'b1;
`endif
          end
        end
        ST_EXEC: begin
          result_reg <= i_alu_result;
          o_tx_valid <= 1'b1;
          state      <= ST_SEND_HI;
        end
        ST_SEND_HI: begin
          if (i_tx_ready) begin
            state <= ST_SEND_LO;
          end
        end
        ST_SEND_LO: begin
          if (i_tx_ready) begin
            o_tx_valid <= 1'b0;
            o_busy     <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: begin
          o_tx_valid <= 1'b0;
          o_busy     <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_uart_ctrl.sv
// Directed bench for alu_uart_ctrl; the timeout scenario runs only when the
// build defines ALU_CTRL_TIMEOUT_EN.
module tb_alu_uart_ctrl;
  import alu_ctrl_pkg::*;

  logic               clk = 1'b0;
  logic               i_reset;
  logic        [7:0]  i_rx_data;
  logic               i_rx_valid;
  logic signed [7:0]  o_operand1;
  logic signed [7:0]  o_operand2;
  logic        [5:0]  o_opcode;
  logic signed [15:0] i_alu_result;
  logic        [7:0]  o_tx_data;
  logic               o_tx_valid;
  logic               i_tx_ready;
  logic               o_busy;
  logic               o_error;

  logic [7:0] op1_u;
  logic [7:0] op2_u;

  int n_chk = 0;
  int n_bad = 0;

  alu_uart_ctrl #(
    .NB_OP          (6),
    .NB_DATA        (8),
    .NB_OUT         (16),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk          (clk),
    .i_reset      (i_reset),
    .i_rx_data    (i_rx_data),
    .i_rx_valid   (i_rx_valid),
    .o_operand1   (o_operand1),
    .o_operand2   (o_operand2),
    .o_opcode     (o_opcode),
    .i_alu_result (i_alu_result),
    .o_tx_data    (o_tx_data),
    .o_tx_valid   (o_tx_valid),
    .i_tx_ready   (i_tx_ready),
    .o_busy       (o_busy),
    .o_error      (o_error)
  );

  always #5 clk = ~clk;

  assign op1_u = o_operand1;
  assign op2_u = o_operand2;

  // Combinational ALU stand-in: signed add or subtract, sign-extended.
  always_comb begin
    i_alu_result = 16'sd0;
    if (o_opcode == OPC_SUB) i_alu_result = o_operand1 - o_operand2;
    else                     i_alu_result = o_operand1 + o_operand2;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    @(negedge clk);
    i_rx_valid = 1'b0;
  endtask

  // Full transaction; stall = cycles with ready low in SEND_HI, drop = inject
  // a stray RX byte during the stall.
  task automatic txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                     input logic [7:0] hi, input logic [7:0] lo,
                     input int stall, input bit drop, input string tag);
    i_tx_ready = 1'b1;
    send_byte(a);
    chk({tag, " op1"}, op1_u, a);
    chk({tag, " busy1"}, o_busy, 1);
    send_byte(b);
    chk({tag, " op2"}, op2_u, b);
    send_byte(op);
    chk({tag, " opc"}, o_opcode, op[5:0]);
    chk({tag, " exec_busy"}, o_busy, 1);
    chk({tag, " exec_vld"}, o_tx_valid, 0);
    i_tx_ready = (stall == 0);
    @(negedge clk);
    for (int k = 0; k < stall; k++) begin
      chk({tag, " hi_vld_stall"}, o_tx_valid, 1);
      chk({tag, " hi_dat_stall"}, o_tx_data, hi);
      if (drop && k == 0) begin
        i_rx_data  = 8'h11;
        i_rx_valid = 1'b1;
      end
      @(negedge clk);
      i_rx_valid = 1'b0;
    end
    if (drop) chk({tag, " op1_kept"}, op1_u, a);
    i_tx_ready = 1'b1;
    chk({tag, " hi_vld"}, o_tx_valid, 1);
    chk({tag, " hi_dat"}, o_tx_data, hi);
    @(negedge clk);
    chk({tag, " lo_vld"}, o_tx_valid, 1);
    chk({tag, " lo_dat"}, o_tx_data, lo);
    chk({tag, " lo_busy"}, o_busy, 1);
    @(negedge clk);
    chk({tag, " idle_vld"}, o_tx_valid, 0);
    chk({tag, " idle_busy"}, o_busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset    = 1'b0;
    i_rx_data  = 8'h00;
    i_rx_valid = 1'b0;
    i_tx_ready = 1'b1;
    #1;
    chk("rst op1", op1_u, 0);
    chk("rst op2", op2_u, 0);
    chk("rst opc", o_opcode, 0);
    chk("rst txd", o_tx_data, 0);
    chk("rst vld", o_tx_valid, 0);
    chk("rst busy", o_busy, 0);
    chk("rst err", o_error, 0);
    @(negedge clk);
    @(negedge clk);
    i_reset = 1'b1;
    @(negedge clk);

    // 5 + 3 = 8, back to back, ready high
    txn(8'h05, 8'h03, 8'h20, 8'h00, 8'h08, 0, 1'b0, "add");
    // -5 + 3 = -2 -> 0xFFFE
    txn(8'hFB, 8'h03, 8'h20, 8'hFF, 8'hFE, 0, 1'b0, "neg");
    // ready held low 5 cycles in SEND_HI
    txn(8'h05, 8'h03, 8'h20, 8'h00, 8'h08, 5, 1'b0, "stall");
    // stray byte while waiting in SEND_HI
    txn(8'h05, 8'h03, 8'h20, 8'h00, 8'h08, 3, 1'b1, "drop");
    // clean follow-up: 10 - 4 = 6, upper opcode bits ignored (0xE2 -> 0x22)
    txn(8'h0A, 8'h04, 8'hE2, 8'h00, 8'h06, 0, 1'b0, "sub");
    chk("hold op1", op1_u, 8'h0A);
    chk("hold opc", o_opcode, 6'h22);

    // reset during SEND_LO
    send_byte(8'h05);
    send_byte(8'h03);
    send_byte(8'h20);
    @(negedge clk);
    @(negedge clk);
    chk("prerst lo_vld", o_tx_valid, 1);
    chk("prerst lo_dat", o_tx_data, 8'h08);
    #2;
    i_reset = 1'b0;
    #1;
    chk("midrst vld", o_tx_valid, 0);
    chk("midrst busy", o_busy, 0);
    chk("midrst op1", op1_u, 0);
    chk("midrst op2", op2_u, 0);
    chk("midrst opc", o_opcode, 0);
    chk("midrst txd", o_tx_data, 0);
    @(negedge clk);
    i_reset = 1'b1;
    @(negedge clk);
    chk("postrst vld", o_tx_valid, 0);
    chk("postrst busy", o_busy, 0);

`ifdef ALU_CTRL_TIMEOUT_EN
    send_byte(8'h07);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      chk("to wait_err", o_error, 0);
      chk("to wait_busy", o_busy, 1);
    end
    @(negedge clk);
    chk("to err", o_error, 1);
    chk("to busy", o_busy, 0);
    chk("to op1", op1_u, 8'h07);
    @(negedge clk);
    chk("to err_pulse", o_error, 0);
    send_byte(8'h09);
    chk("to new_op1", op1_u, 8'h09);
    chk("to new_busy", o_busy, 1);
    send_byte(8'h01);
    send_byte(8'h20);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("to drain_busy", o_busy, 0);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
